regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the register file's two write ports (C and D) among three writeback requesters: ALU, load unit and mult/div unit.
- Grants up to two requests per cycle using rotating (round-robin) priority.
- Never issues two writes to the same register in one cycle.
- Drives the register file write ports from registers, and exports a pending-write mask for the hazard unit.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 = ALU, 1 = load, 2 = mult/div.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset; state clears on a posedge where reset=0.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_W  destination register per requester.
- req_data  in  NUM_REQ*DATA_W  write data per requester.
- req_ready  out  NUM_REQ  combinational grant; the handshake completes when valid and ready are both high.
- write_addr_c  out  ADDR_W  register file port C address.
- write_enable_c  out  1  port C enable.
- write_data_c  out  DATA_W  port C data.
- write_addr_d  out  ADDR_W  port D address.
- write_enable_d  out  1  port D enable.
- write_data_d  out  DATA_W  port D data.
- pending_mask  out  32  bit r set when register r has an in-flight write or an ungranted valid request.

Behaviour:
- Reset (reset=0 at posedge):
  - All write_* outputs go to 0.
  - rr_ptr goes to 0.
  - req_ready is forced to 0 combinationally while reset=0.
  - pending_mask is 0 on the cycle after reset.
- Handshake rules:
  - A requester holds valid, addr and data stable until it sees ready.
  - Dropping valid before ready is a protocol error; the behaviour is undefined and the bench asserts on it.
- Scan order: requesters are scanned from rr_ptr upward, wrapping modulo NUM_REQ.
- Address-0 requests:
  - Granted immediately (ready=1) whenever reset=1.
  - Consume no port and produce no write enable.
- Non-zero requests:
  - The first in scan order takes port C; the second takes port D.
  - A requester whose addr equals the port C candidate's addr is skipped, and the scan continues to the next requester for port D.
  - Any further requests get ready=0.
- Write pipeline:
  - A granted request appears on its port's write_* outputs exactly 1 cycle after the handshake, with write_enable high for exactly one cycle.
  - If there is no grant for a port, its enable is 0; addr and data hold their previous values.
- rr_ptr update:
  - If any non-zero grant occurs, rr_ptr becomes (index of the last non-zero grantee + 1) mod NUM_REQ.
  - Otherwise rr_ptr is unchanged.
  - Address-0 grants do not move rr_ptr.
- Fairness: a continuously valid requester is granted within NUM_REQ-1 cycles.
- pending_mask is the OR of:
  - one-hot(write_addr_c) when write_enable_c is set;
  - one-hot(write_addr_d) when write_enable_d is set;
  - one-hot(req_addr[i]) for each valid, not-ready i with a non-zero address.
  - It is combinational from registered state and inputs.
  - Bit 0 is always 0.
- Same-address back-to-back writes are legal: the older write lands first, so the register file holds the newer value afterwards.
- Reset asserted mid-operation: the registered grant is dropped (enables go to 0) and the register file receives no write on the following edge.

Decomposition:
- Package regfile_arb_pkg holds:
  - constants NUM_REQ, ADDR_W, DATA_W;
  - requester indices REQ_ALU=0, REQ_LOAD=1, REQ_MULDIV=2;
  - typedef wr_req_t {valid, addr, data};
  - typedef wr_port_t {enable, addr, data}.
- One natural sub-module, rr_two_grant_picker (combinational): takes valids, addresses and rr_ptr, and returns the port C/D grant indices plus their valid bits.
- The top level holds rr_ptr, the output registers and pending_mask.

Test Plan:
- Reset: drive reset=0 for 2 cycles with all valids high -> req_ready=000, write_enable_c/d=0, pending_mask=0; on the first reset=1 cycle with ptr=0, ALU and load are granted.
- Two distinct requests: ALU addr=5 data=0x11, load addr=6 data=0x22 -> both ready in the same cycle; next cycle port C=(5,0x11,en=1) and port D=(6,0x22,en=1); rr_ptr=2.
- Three requests, rr_ptr=0: addrs 3, 4, 7 -> cycle 1 grants 0 and 1; cycle 2 grants 2 (rr_ptr=2) -> port C=(7,data) and port D enable=0.
- Address conflict: ALU addr=9 and mult/div addr=9, rr_ptr=0 -> only ALU is ready; pending_mask[9]=1; mult/div is granted the next cycle and its value is written last.
- Address zero: load addr=0 with ALU addr=8 and mult/div addr=10 -> all three ready in one cycle; ports carry 8 and 10; no enable for address 0; rr_ptr=0 after the cycle.
- Mid-operation reset: grant ALU addr=12, then pull reset=0 on the next edge -> write_enable_c=0 after that edge and register 12 is unchanged.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Requester indices, the round-robin pointer type and the request/port records.
package regfile_arb_pkg;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PTR_W   = $clog2(NUM_REQ);

    typedef logic [PTR_W-1:0] req_idx_t;

    localparam req_idx_t REQ_ALU    = req_idx_t'(0);
    localparam req_idx_t REQ_LOAD   = req_idx_t'(1);
    localparam req_idx_t REQ_MULDIV = req_idx_t'(2);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef struct packed {
        logic              enable;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_port_t;

    // Successor in scan order, wrapping modulo NUM_REQ.
    function automatic req_idx_t next_idx(req_idx_t i);
        return (i == req_idx_t'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus plus register-file write ports and hazard mask.
// The arbiter uses the slave modport; the requester/register-file side uses master.
interface regfile_write_arbiter_if;
    import regfile_arb_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    logic [ADDR_W-1:0]         write_addr_c;
    logic                      write_enable_c;
    logic [DATA_W-1:0]         write_data_c;
    logic [ADDR_W-1:0]         write_addr_d;
    logic                      write_enable_d;
    logic [DATA_W-1:0]         write_data_d;

    logic [31:0]               pending_mask;

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready,
        output write_addr_c, write_enable_c, write_data_c,
        output write_addr_d, write_enable_d, write_data_d,
        output pending_mask
    );

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready,
        input  write_addr_c, write_enable_c, write_data_c,
        input  write_addr_d, write_enable_d, write_data_d,
        input  pending_mask
    );

endinterface

// File: rtl/regfile_write_arbiter_picker.sv
// Combinational round-robin picker choosing up to two non-zero-address writers.
// Port C takes the first in scan order; port D the next one with a different address.
module rr_two_grant_picker
    import regfile_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0]             valid_i,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_i,
    input  req_idx_t                       rr_ptr_i,
    output req_idx_t                       grant_c_idx_o,
    output logic                           grant_c_vld_o,
    output req_idx_t                       grant_d_idx_o,
    output logic                           grant_d_vld_o
);

    always_comb begin
        req_idx_t idx;
        req_idx_t c_idx;
        req_idx_t d_idx;
        logic     c_vld;
        logic     d_vld;

        idx   = rr_ptr_i;
        c_idx = '0;
        d_idx = '0;
        c_vld = 1'b0;
        d_vld = 1'b0;

        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (valid_i[idx] && (addr_i[idx] != '0)) begin
                if (!c_vld) begin
                    c_vld = 1'b1;
                    c_idx = idx;
                end else if (!d_vld && (addr_i[idx] != addr_i[c_idx])) begin
                    d_vld = 1'b1;
                    d_idx = idx;
                end
            end
            idx = next_idx(idx);
        end

        grant_c_idx_o = c_idx;
        grant_c_vld_o = c_vld;
        grant_d_idx_o = d_idx;
        grant_d_vld_o = d_vld;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares register-file write ports C and D among ALU, load and mult/div writeback.
// Holds the round-robin pointer, registered write ports and the pending-write mask.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);

    wr_req_t                        req [NUM_REQ];
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_a;

    req_idx_t rr_ptr_q, rr_ptr_d;
    wr_port_t port_c_q, port_c_d;
    wr_port_t port_d_q, port_d_d;

    req_idx_t c_idx, d_idx;
    logic     c_vld, d_vld;

    logic [NUM_REQ-1:0] ready;
    logic [31:0]        pending;

    assign req_addr_a = bus.req_addr;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req[i].valid = bus.req_valid[i];
            req[i].addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
            req[i].data  = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    rr_two_grant_picker u_picker (
        .valid_i       (bus.req_valid),
        .addr_i        (req_addr_a),
        .rr_ptr_i      (rr_ptr_q),
        .grant_c_idx_o (c_idx),
        .grant_c_vld_o (c_vld),
        .grant_d_idx_o (d_idx),
        .grant_d_vld_o (d_vld)
    );

    // Address-0 requests are always accepted: they need no port and write nothing.
    always_comb begin
        ready = '0;
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req[i].valid &&
                    ((req[i].addr == '0) ||
                     (c_vld && (c_idx == req_idx_t'(i))) ||
                     (d_vld && (d_idx == req_idx_t'(i))))) begin
                    ready[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        port_c_d        = port_c_q;
        port_d_d        = port_d_q;
        port_c_d.enable = c_vld;
        port_d_d.enable = d_vld;
        if (c_vld) begin
            port_c_d.addr = req[c_idx].addr;
            port_c_d.data = req[c_idx].data;
        end
        if (d_vld) begin
            port_d_d.addr = req[d_idx].addr;
            port_d_d.data = req[d_idx].data;
        end

        rr_ptr_d = rr_ptr_q;
        if (d_vld) begin
            rr_ptr_d = next_idx(d_idx);
        end else if (c_vld) begin
            rr_ptr_d = next_idx(c_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q <= '0;
            port_c_q <= '0;
            port_d_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            port_c_q <= port_c_d;
            port_d_q <= port_d_d;
        end
    end

    always_comb begin
        pending = '0;
        if (port_c_q.enable) pending[port_c_q.addr] = 1'b1;
        if (port_d_q.enable) pending[port_d_q.addr] = 1'b1;
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req[i].valid && !ready[i] && (req[i].addr != '0)) begin
                    pending[req[i].addr] = 1'b1;
                end
            end
        end
        pending[0] = 1'b0;
    end

    assign bus.req_ready      = ready;
    assign bus.write_addr_c   = port_c_q.addr;
    assign bus.write_enable_c = port_c_q.enable;
    assign bus.write_data_c   = port_c_q.data;
    assign bus.write_addr_d   = port_d_q.addr;
    assign bus.write_enable_d = port_d_q.enable;
    assign bus.write_data_d   = port_d_q.data;
    assign bus.pending_mask   = pending;

endmodule
